// File: rtl/dest_reg_pipe_hazard.sv
// -----------------------------------------------------------------------------
// dest_reg_pipe_hazard
//
// Purpose:
//   Carries the destination register number selected in ID, together with the
//   control bits it needs, through the EX, MEM and WB pipeline registers.
//   The block also:
//     - detects load-use hazards and stalls IF/ID for one cycle;
//     - generates the EX-stage operand forwarding selects;
//     - drives the register-file write address and write enable at WB.
//
// Optional feature (macro DEST_PIPE_STALL_CNT_EN):
//   Adds a saturating 16-bit stall counter (stall_count) and its synchronous
//   clear input (stall_count_clr). The default build has neither port.
//
// Parameters:
//   REG_W     register-number width
//   ZERO_REG  hard-wired zero register; it never matches for hazards or
//             forwarding
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   id_valid              ID holds a real instruction
//   id_dest_reg           destination register chosen in ID (rt/rd/31)
//   id_reg_write          ID instruction writes a register
//   id_mem_read           ID instruction is a load
//   id_rs, id_rt          ID source register numbers
//   id_uses_rs/_rt        ID instruction actually reads rs / rt
//   flush                 squash the ID instruction (bubble into EX)
//   stall                 hold PC and IF/ID; bubble into EX
//   fwd_a, fwd_b          EX operand select: 00 regfile, 10 MEM, 01 WB
//   ex_dest_reg           EX-stage destination register
//   mem_dest_reg          MEM-stage destination register
//   mem_mem_read          MEM-stage load flag
//   wb_dest_reg           register-file write address
//   wb_reg_write          register-file write enable
//   stall_count_clr       (optional) synchronous clear of stall_count
//   stall_count           (optional) saturating count of stall cycles
// -----------------------------------------------------------------------------
module dest_reg_pipe_hazard #(
  parameter int               REG_W    = 5,
  parameter logic [REG_W-1:0] ZERO_REG = {REG_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_dest_reg,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [REG_W-1:0] ex_dest_reg,
  output logic [REG_W-1:0] mem_dest_reg,
  output logic             mem_mem_read,
  output logic [REG_W-1:0] wb_dest_reg,
  output logic             wb_reg_write
`ifdef DEST_PIPE_STALL_CNT_EN
  ,
  input  logic             stall_count_clr,
  output logic [15:0]      stall_count
`endif
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic             ex_valid_q,     ex_valid_d;
  logic [REG_W-1:0] ex_dest_q,      ex_dest_d;
  logic             ex_reg_write_q, ex_reg_write_d;
  logic             ex_mem_read_q,  ex_mem_read_d;
  logic [REG_W-1:0] ex_rs_q,        ex_rs_d;
  logic [REG_W-1:0] ex_rt_q,        ex_rt_d;
  logic             ex_uses_rs_q,   ex_uses_rs_d;
  logic             ex_uses_rt_q,   ex_uses_rt_d;

  logic             mem_valid_q,     mem_valid_d;
  logic [REG_W-1:0] mem_dest_q,      mem_dest_d;
  logic             mem_reg_write_q, mem_reg_write_d;
  logic             mem_mem_read_q,  mem_mem_read_d;

  logic             wb_valid_q,     wb_valid_d;
  logic [REG_W-1:0] wb_dest_q,      wb_dest_d;
  logic             wb_reg_write_q, wb_reg_write_d;
  logic             wb_mem_read_q,  wb_mem_read_d;

  // Combinational helpers
  logic ex_load_live_s;
  logic rs_dep_s;
  logic rt_dep_s;
  logic stall_s;
  logic bubble_s;
  logic mem_fwd_ok_s;
  logic wb_fwd_ok_s;

  // Forwarding select for one EX source operand. The MEM stage wins over WB
  // because it holds the younger producer.
  function automatic logic [1:0] fwd_select(
    input logic             uses_src,
    input logic [REG_W-1:0] src,
    input logic             mem_ok,
    input logic [REG_W-1:0] mem_dest,
    input logic             wb_ok,
    input logic [REG_W-1:0] wb_dest
  );
    logic [1:0] sel;
    if (uses_src && mem_ok && (mem_dest == src)) begin
      sel = FWD_MEM;
    end else if (uses_src && wb_ok && (wb_dest == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Load-use detection against the instruction in EX; flush suppresses it.
  always_comb begin
    ex_load_live_s = ex_valid_q & ex_mem_read_q & (ex_dest_q != ZERO_REG);
    rs_dep_s       = id_uses_rs & (id_rs == ex_dest_q);
    rt_dep_s       = id_uses_rt & (id_rt == ex_dest_q);
    if (flush) begin
      stall_s = 1'b0;
    end else begin
      stall_s = id_valid & ex_load_live_s & (rs_dep_s | rt_dep_s);
    end
    bubble_s = flush | stall_s;
  end

  // Producer qualification. A load still in MEM has no data yet, so it is
  // never a MEM-stage source; the check then falls through to WB.
  always_comb begin
    mem_fwd_ok_s = mem_valid_q & mem_reg_write_q & ~mem_mem_read_q &
                   (mem_dest_q != ZERO_REG);
    wb_fwd_ok_s  = wb_valid_q & wb_reg_write_q & (wb_dest_q != ZERO_REG);
  end

  // EX operand forwarding selects.
  always_comb begin
    fwd_a = fwd_select(ex_uses_rs_q, ex_rs_q, mem_fwd_ok_s, mem_dest_q,
                       wb_fwd_ok_s, wb_dest_q);
    fwd_b = fwd_select(ex_uses_rt_q, ex_rt_q, mem_fwd_ok_s, mem_dest_q,
                       wb_fwd_ok_s, wb_dest_q);
  end

  // Next EX contents: ID fields, or an all-zero bubble on flush/stall.
  always_comb begin
    if (bubble_s) begin
      ex_valid_d     = 1'b0;
      ex_dest_d      = {REG_W{1'b0}};
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_rs_d        = {REG_W{1'b0}};
      ex_rt_d        = {REG_W{1'b0}};
      ex_uses_rs_d   = 1'b0;
      ex_uses_rt_d   = 1'b0;
    end else begin
      ex_valid_d     = id_valid;
      ex_dest_d      = id_dest_reg;
      ex_reg_write_d = id_reg_write;
      ex_mem_read_d  = id_mem_read;
      ex_rs_d        = id_rs;
      ex_rt_d        = id_rt;
      ex_uses_rs_d   = id_uses_rs;
      ex_uses_rt_d   = id_uses_rt;
    end
  end

  // MEM and WB advance unconditionally.
  always_comb begin
    mem_valid_d     = ex_valid_q;
    mem_dest_d      = ex_dest_q;
    mem_reg_write_d = ex_reg_write_q;
    mem_mem_read_d  = ex_mem_read_q;
    wb_valid_d      = mem_valid_q;
    wb_dest_d       = mem_dest_q;
    wb_reg_write_d  = mem_reg_write_q;
    wb_mem_read_d   = mem_mem_read_q;
  end

  // Stage registers; reset discards every in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_dest_q       <= {REG_W{1'b0}};
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_rs_q         <= {REG_W{1'b0}};
      ex_rt_q         <= {REG_W{1'b0}};
      ex_uses_rs_q    <= 1'b0;
      ex_uses_rt_q    <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_dest_q      <= {REG_W{1'b0}};
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_dest_q       <= {REG_W{1'b0}};
      wb_reg_write_q  <= 1'b0;
      wb_mem_read_q   <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_dest_q       <= ex_dest_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_uses_rs_q    <= ex_uses_rs_d;
      ex_uses_rt_q    <= ex_uses_rt_d;
      mem_valid_q     <= mem_valid_d;
      mem_dest_q      <= mem_dest_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_mem_read_q  <= mem_mem_read_d;
      wb_valid_q      <= wb_valid_d;
      wb_dest_q       <= wb_dest_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_read_q   <= wb_mem_read_d;
    end
  end

  // Output drive; the write enable ignores bubbles and the zero register.
  always_comb begin
    stall        = stall_s;
    ex_dest_reg  = ex_dest_q;
    mem_dest_reg = mem_dest_q;
    mem_mem_read = mem_mem_read_q;
    wb_dest_reg  = wb_dest_q;
    wb_reg_write = wb_valid_q & wb_reg_write_q & (wb_dest_q != ZERO_REG);
  end

`ifdef DEST_PIPE_STALL_CNT_EN
  logic [15:0] stall_count_q, stall_count_d;

  // Saturating stall counter; the clear beats the increment.
  always_comb begin
    if (stall_count_clr) begin
      stall_count_d = 16'h0000;
    end else if (stall_s && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'h0001;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= 16'h0000;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  // Counter output.
  always_comb begin
    stall_count = stall_count_q;
  end
`endif

endmodule

// File: tb/tb_dest_reg_pipe_hazard.sv
// Self-checking bench for dest_reg_pipe_hazard: a directed vector table,
// hand-written reset sequences, and randomized traffic against a reference
// model of the EX/MEM/WB pipe.
module tb_dest_reg_pipe_hazard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_reg_write, id_mem_read, id_uses_rs, id_uses_rt, flush;
  logic [4:0] id_dest_reg, id_rs, id_rt;
  logic       stall, mem_mem_read, wb_reg_write;
  logic [1:0] fwd_a, fwd_b;
  logic [4:0] ex_dest_reg, mem_dest_reg, wb_dest_reg;
`ifdef DEST_PIPE_STALL_CNT_EN
  logic        stall_count_clr;
  logic [15:0] stall_count;
  int          m_cnt;
`endif

  dest_reg_pipe_hazard #(.REG_W(5), .ZERO_REG(5'd0)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_dest_reg(id_dest_reg),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_dest_reg(ex_dest_reg), .mem_dest_reg(mem_dest_reg),
    .mem_mem_read(mem_mem_read), .wb_dest_reg(wb_dest_reg),
    .wb_reg_write(wb_reg_write)
`ifdef DEST_PIPE_STALL_CNT_EN
    , .stall_count_clr(stall_count_clr), .stall_count(stall_count)
`endif
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model: instruction slots 0=EX 1=MEM 2=WB ------
  typedef struct {
    logic v; logic [4:0] d; logic rw; logic mr;
    logic [4:0] rs; logic [4:0] rt; logic urs; logic urt;
  } slot_t;
  slot_t pipe[3];
  slot_t empty_slot = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};

  function automatic logic m_stall();
    if (flush || !id_valid) return 1'b0;
    if (!(pipe[0].v && pipe[0].mr && pipe[0].d != 5'd0)) return 1'b0;
    return (id_uses_rs && id_rs == pipe[0].d) || (id_uses_rt && id_rt == pipe[0].d);
  endfunction

  // Youngest qualifying producer wins; a load still in MEM cannot supply data.
  function automatic logic [1:0] m_fwd(input logic use_src, input logic [4:0] src);
    for (int p = 1; p <= 2; p++) begin
      if (use_src && pipe[p].v && pipe[p].rw && pipe[p].d != 5'd0 &&
          pipe[p].d == src && !(p == 1 && pipe[p].mr))
        return (p == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  always @(posedge clk) begin : model_update
    logic st;
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = empty_slot;
`ifdef DEST_PIPE_STALL_CNT_EN
      m_cnt = 0;
`endif
    end else begin
      st = m_stall();
`ifdef DEST_PIPE_STALL_CNT_EN
      if (stall_count_clr) m_cnt = 0;
      else if (st && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (flush || st) pipe[0] = empty_slot;
      else pipe[0] = '{id_valid, id_dest_reg, id_reg_write, id_mem_read,
                       id_rs, id_rt, id_uses_rs, id_uses_rt};
    end
  end

  task automatic drive(input logic r, input logic f, input logic v, input logic [4:0] d,
                       input logic rw, input logic mr, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urs, input logic urt);
    rst = r; flush = f; id_valid = v; id_dest_reg = d; id_reg_write = rw;
    id_mem_read = mr; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
  endtask

  task automatic drive_random(input logic r, input logic v);
    drive(r, 1'b0, v, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
  endtask

  task automatic check_outs(input string tag, input logic st, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [4:0] ex, input logic [4:0] mem,
                            input logic mmr, input logic [4:0] wb, input logic wrw);
    chk({tag, ".stall"}, 16'(stall), 16'(st));
    chk({tag, ".fwd_a"}, 16'(fwd_a), 16'(fa));
    chk({tag, ".fwd_b"}, 16'(fwd_b), 16'(fb));
    chk({tag, ".ex_dest"}, 16'(ex_dest_reg), 16'(ex));
    chk({tag, ".mem_dest"}, 16'(mem_dest_reg), 16'(mem));
    chk({tag, ".mem_mem_read"}, 16'(mem_mem_read), 16'(mmr));
    chk({tag, ".wb_dest"}, 16'(wb_dest_reg), 16'(wb));
    chk({tag, ".wb_reg_write"}, 16'(wb_reg_write), 16'(wrw));
  endtask

  task automatic check_model(input string tag);
    check_outs(tag, m_stall(), m_fwd(pipe[0].urs, pipe[0].rs), m_fwd(pipe[0].urt, pipe[0].rt),
               pipe[0].d, pipe[1].d, pipe[1].mr, pipe[2].d,
               pipe[2].v && pipe[2].rw && pipe[2].d != 5'd0);
`ifdef DEST_PIPE_STALL_CNT_EN
    chk({tag, ".stall_count"}, stall_count, 16'(m_cnt));
`endif
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    logic r; logic f; logic v; logic [4:0] d; logic rw; logic mr;
    logic [4:0] rs; logic [4:0] rt; logic urs; logic urt;
    logic e_st; logic [1:0] e_fa; logic [1:0] e_fb; logic [4:0] e_ex;
    logic [4:0] e_mem; logic e_mmr; logic [4:0] e_wb; logic e_wrw;
  } vec_t;
  vec_t tbl[26];

  // Argument order: rst flush valid dest rw mr rs rt urs urt | stall fa fb ex mem mmr wb wrw
  function automatic vec_t mk(input logic r, f, v, input logic [4:0] d, input logic rw, mr,
                              input logic [4:0] rs, rt, input logic urs, urt,
                              input logic st, input logic [1:0] fa, fb,
                              input logic [4:0] ex, mem, input logic mmr,
                              input logic [4:0] wb, input logic wrw);
    vec_t t;
    t = '{r, f, v, d, rw, mr, rs, rt, urs, urt, st, fa, fb, ex, mem, mmr, wb, wrw};
    return t;
  endfunction

  initial begin
    // pass-through: add dest 8
    tbl[0]  = mk(0,0,1, 8,1,0, 1, 2,1,1,  0,0,0,  0, 0,0, 0,0);
    tbl[1]  = mk(0,0,0, 0,0,0, 0, 0,0,0,  0,0,0,  8, 0,0, 0,0);
    tbl[2]  = mk(0,0,0, 0,0,0, 0, 0,0,0,  0,0,0,  0, 8,0, 0,0);
    tbl[3]  = mk(0,0,0, 0,0,0, 0, 0,0,0,  0,0,0,  0, 0,0, 8,1);
    // load-use: lw 9; add rs=9 stalls once, then forwards from WB
    tbl[4]  = mk(0,0,1, 9,1,1, 2, 0,1,0,  0,0,0,  0, 0,0, 0,0);
    tbl[5]  = mk(0,0,1, 3,1,0, 9, 4,1,1,  1,0,0,  9, 0,0, 0,0);
    tbl[6]  = mk(0,0,1, 3,1,0, 9, 4,1,1,  0,0,0,  0, 9,1, 0,0);
    tbl[7]  = mk(0,0,0, 0,0,0, 0, 0,0,0,  0,1,0,  3, 0,0, 9,1);
    // forward priority: add 10, add 10, sub 10,10 -> both from MEM
    tbl[8]  = mk(0,0,1,10,1,0, 1, 2,1,1,  0,0,0,  0, 3,0, 0,0);
    tbl[9]  = mk(0,0,1,10,1,0, 3, 4,1,1,  0,0,0, 10, 0,0, 3,1);
    tbl[10] = mk(0,0,1,12,1,0,10,10,1,1,  0,0,0, 10,10,0, 0,0);
    tbl[11] = mk(0,0,0, 0,0,0, 0, 0,0,0,  0,2,2, 12,10,0,10,1);
    // add 10, add 11, sub 10,11 -> A from WB, B from MEM
    tbl[12] = mk(0,0,1,10,1,0, 1, 2,1,1,  0,0,0,  0,12,0,10,1);
    tbl[13] = mk(0,0,1,11,1,0, 1, 2,1,1,  0,0,0, 10, 0,0,12,1);
    tbl[14] = mk(0,0,1,12,1,0,10,11,1,1,  0,0,0, 11,10,0, 0,0);
    tbl[15] = mk(0,0,0, 0,0,0, 0, 0,0,0,  0,1,2, 12,11,0,10,1);
    // zero register: lw 0, add rs=0 -> no stall, no forward, no write
    tbl[16] = mk(0,0,1, 0,1,1, 2, 0,1,0,  0,0,0,  0,12,0,11,1);
    tbl[17] = mk(0,0,1, 5,1,0, 0, 0,1,1,  0,0,0,  0, 0,0,12,1);
    tbl[18] = mk(0,0,1, 6,1,0, 0, 0,1,1,  0,0,0,  5, 0,1, 0,0);
    tbl[19] = mk(0,0,0, 0,0,0, 0, 0,0,0,  0,0,0,  6, 5,0, 0,0);
    // flush beats stall
    tbl[20] = mk(0,0,1, 9,1,1, 2, 0,1,0,  0,0,0,  0, 6,0, 5,1);
    tbl[21] = mk(0,1,1, 3,1,0, 9, 0,1,0,  0,0,0,  9, 0,0, 6,1);
    tbl[22] = mk(0,0,0, 0,0,0, 0, 0,0,0,  0,0,0,  0, 9,1, 0,0);
    // reset together with flush and a pending load-use
    tbl[23] = mk(0,0,1, 9,1,1, 2, 0,1,0,  0,0,0,  0, 0,0, 9,1);
    tbl[24] = mk(1,1,1, 3,1,0, 9, 0,1,0,  0,0,0,  9, 0,0, 0,0);
    tbl[25] = mk(0,0,1, 3,1,0, 9, 0,1,0,  0,0,0,  0, 0,0, 0,0);
  end

  // ---------------- test sequence ------------------------------------------
  initial begin
`ifdef DEST_PIPE_STALL_CNT_EN
    stall_count_clr = 1'b0;
`endif
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Reset held two cycles with random inputs: outputs must read zero.
    @(negedge clk); drive_random(1'b1, 1'($urandom));
    @(negedge clk); drive_random(1'b1, 1'($urandom)); #1;
    check_outs("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    // First cycle after release with id_valid low: still all zero.
    @(negedge clk); drive_random(1'b0, 1'b0); #1;
    check_outs("reset_release", 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset again to start the table from an empty pipe.
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
    check_model("reset_again");

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].rw, tbl[i].mr,
            tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt);
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_st, tbl[i].e_fa, tbl[i].e_fb,
                 tbl[i].e_ex, tbl[i].e_mem, tbl[i].e_mmr, tbl[i].e_wb, tbl[i].e_wrw);
    end

    // Randomized traffic over a small register range to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
`ifdef DEST_PIPE_STALL_CNT_EN
      stall_count_clr = ($urandom_range(0, 31) == 0);
`endif
      #1;
      check_model($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
